// File: rtl/fib_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fib_seq_ctrl
//
// Sequencer for the BCD Fibonacci datapath. A start tick latches the 2-digit
// BCD operand from the switches, checks it, and then runs three sub-units in
// turn through start/done handshakes:
//   bcd2bin   -> converts the operand to binary
//   fibonacci -> computes fib(n)
//   bin2bcd   -> converts fib(n) back to 4 BCD digits for the display
// Bad BCD digits, operands above N_MAX and a sub-unit that never answers
// (watchdog) all end the run early with a defined result and flag.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, bcd_in          start tick and {tens,ones} BCD operand
//   b2b_start/bcd/done/bin bcd2bin handshake, operand out, binary in
//   fib_start/n/done/f     fibonacci handshake, index out, result in
//   bcd_start/bin/done/digits  bin2bcd handshake, binary out, digits in
//   result                 displayed BCD value, held until next accepted start
//   busy                   high whenever the sequencer is not idle
//   done_tick              1-cycle pulse when result is updated
//   ovf                    operand above N_MAX (result = 9999)
//   err                    invalid BCD digit or watchdog timeout (result = 0000)
// ---------------------------------------------------------------------------
module fib_seq_ctrl #(
    parameter int N_MAX       = 20,
    parameter int FIB_W       = 14,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       bcd_in,
    output logic             b2b_start,
    output logic [7:0]       b2b_bcd,
    input  logic             b2b_done,
    input  logic [6:0]       b2b_bin,
    output logic             fib_start,
    output logic [4:0]       fib_n,
    input  logic             fib_done,
    input  logic [FIB_W-1:0] fib_f,
    output logic             bcd_start,
    output logic [FIB_W-1:0] bcd_bin,
    input  logic             bcd_done,
    input  logic [15:0]      bcd_digits,
    output logic [15:0]      result,
    output logic             busy,
    output logic             done_tick,
    output logic             ovf,
    output logic             err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [15:0] RESULT_OVF = 16'h9999;
    localparam logic [15:0] RESULT_ERR = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        B2B,
        FIB,
        B2D,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WD_W-1:0] wd_cnt;

    logic bcd_bad;
    logic operand_ovf;
    logic waiting;
    logic wd_expired;

    assign bcd_bad     = (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
    assign operand_ovf = b2b_bin > 7'(N_MAX);
    assign waiting     = (state == B2B) || (state == FIB) || (state == B2D);
    // The counter starts at 0 on entry, so the wait that ends on this edge is
    // the TIMEOUT_CYC-th one. A done seen on the same edge is tested first.
    assign wd_expired  = wd_cnt == WD_W'(TIMEOUT_CYC - 1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_next is given a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // start is only looked at here, so starts while busy (and
                // during the DONE cycle) fall away without being queued.
                if (start) begin
                    state_next = bcd_bad ? DONE : B2B;
                end
            end
            B2B: begin
                if (b2b_done) begin
                    state_next = operand_ovf ? DONE : FIB;
                end else if (wd_expired) begin
                    state_next = DONE;
                end
            end
            FIB: begin
                if (fib_done || wd_expired) begin
                    state_next = fib_done ? B2D : DONE;
                end
            end
            B2D: begin
                if (bcd_done || wd_expired) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs decoded from state
    // -----------------------------------------------------------------------
    always_comb begin
        busy      = state != IDLE;
        done_tick = state == DONE;
    end

    // -----------------------------------------------------------------------
    // Datapath: latched operands, start pulses, result flags, watchdog
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b2b_start <= 1'b0;
            fib_start <= 1'b0;
            bcd_start <= 1'b0;
            b2b_bcd   <= '0;
            fib_n     <= '0;
            bcd_bin   <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            // Start strobes are single-cycle: they default low and are set
            // only on the edge that moves into the state awaiting that unit.
            b2b_start <= 1'b0;
            fib_start <= 1'b0;
            bcd_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        b2b_bcd <= bcd_in;
                        ovf     <= 1'b0;
                        err     <= 1'b0;
                        if (bcd_bad) begin
                            result <= RESULT_ERR;
                            err    <= 1'b1;
                        end else begin
                            b2b_start <= 1'b1;
                        end
                    end
                end
                B2B: begin
                    if (b2b_done) begin
                        if (operand_ovf) begin
                            result <= RESULT_OVF;
                            ovf    <= 1'b1;
                        end else begin
                            fib_n     <= b2b_bin[4:0];
                            fib_start <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        result <= RESULT_ERR;
                        err    <= 1'b1;
                    end
                end
                FIB: begin
                    if (fib_done) begin
                        bcd_bin   <= fib_f;
                        bcd_start <= 1'b1;
                    end else if (wd_expired) begin
                        result <= RESULT_ERR;
                        err    <= 1'b1;
                    end
                end
                B2D: begin
                    if (bcd_done) begin
                        result <= bcd_digits;
                    end else if (wd_expired) begin
                        result <= RESULT_ERR;
                        err    <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Watchdog: cleared whenever the state changes (covers entry into
            // each wait state), counts only while staying in a wait state.
            if (waiting && (state_next == state)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fib_seq_ctrl
//
// Self-checking bench for fib_seq_ctrl. The three sub-units are behavioural
// models with programmable latency (the fibonacci model can also hang).
// Each accepted start pushes the expected outcome onto a queue; a monitor
// pops and compares it when done_tick is seen.
// ---------------------------------------------------------------------------
module tb_fib_seq_ctrl;

    localparam int N_MAX       = 20;
    localparam int FIB_W       = 14;
    localparam int TIMEOUT_CYC = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [7:0]       bcd_in;
    logic             b2b_start;
    logic [7:0]       b2b_bcd;
    logic             b2b_done;
    logic [6:0]       b2b_bin;
    logic             fib_start;
    logic [4:0]       fib_n;
    logic             fib_done;
    logic [FIB_W-1:0] fib_f;
    logic             bcd_start;
    logic [FIB_W-1:0] bcd_bin;
    logic             bcd_done;
    logic [15:0]      bcd_digits;
    logic [15:0]      result;
    logic             busy;
    logic             done_tick;
    logic             ovf;
    logic             err;

    fib_seq_ctrl #(
        .N_MAX      (N_MAX),
        .FIB_W      (FIB_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bcd_in    (bcd_in),
        .b2b_start (b2b_start),
        .b2b_bcd   (b2b_bcd),
        .b2b_done  (b2b_done),
        .b2b_bin   (b2b_bin),
        .fib_start (fib_start),
        .fib_n     (fib_n),
        .fib_done  (fib_done),
        .fib_f     (fib_f),
        .bcd_start (bcd_start),
        .bcd_bin   (bcd_bin),
        .bcd_done  (bcd_done),
        .bcd_digits(bcd_digits),
        .result    (result),
        .busy      (busy),
        .done_tick (done_tick),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference functions
    // -----------------------------------------------------------------------
    function automatic int fib(input int n);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        err;
        int          nb;
        int          nf;
        int          nd;
    } exp_t;

    function automatic exp_t mk_exp(input logic [15:0] r, input logic o, input logic e,
                                    input int nb, input int nf, input int nd);
        exp_t x;
        x.res = r;
        x.ovf = o;
        x.err = e;
        x.nb  = nb;
        x.nf  = nf;
        x.nd  = nd;
        return x;
    endfunction

    function automatic exp_t exp_of(input logic [7:0] b);
        int v;
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return mk_exp(16'h0000, 1'b0, 1'b1, 0, 0, 0);
        v = int'(b[7:4]) * 10 + int'(b[3:0]);
        if (v > N_MAX) return mk_exp(16'h9999, 1'b1, 1'b0, 1, 0, 0);
        return mk_exp(to_bcd(fib(v)), 1'b0, 1'b0, 1, 1, 1);
    endfunction

    // -----------------------------------------------------------------------
    // Sub-unit models (evaluated on the falling edge, away from DUT edges)
    // -----------------------------------------------------------------------
    int          b2b_lat = 1, fib_lat = 1, bcd_lat = 1;
    bit          fib_hang = 1'b0;
    bit          b2b_pend, fib_pend, bcd_pend;
    int          b2b_cnt, fib_cnt, bcd_cnt;
    logic [6:0]  b2b_hold;
    logic [13:0] fib_hold;
    logic [15:0] bcd_hold;

    always @(negedge clk) begin
        b2b_done = 1'b0;
        if (!rst_n) begin
            b2b_pend = 1'b0;
        end else if (b2b_start) begin
            b2b_pend = 1'b1;
            b2b_cnt  = b2b_lat;
            b2b_hold = 7'(int'(b2b_bcd[7:4]) * 10 + int'(b2b_bcd[3:0]));
        end else if (b2b_pend) begin
            if (b2b_cnt <= 1) begin
                b2b_done = 1'b1;
                b2b_bin  = b2b_hold;
                b2b_pend = 1'b0;
            end else begin
                b2b_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        fib_done = 1'b0;
        if (!rst_n) begin
            fib_pend = 1'b0;
        end else if (fib_start) begin
            fib_pend = !fib_hang;
            fib_cnt  = fib_lat;
            fib_hold = 14'(fib(int'(fib_n)));
        end else if (fib_pend) begin
            if (fib_cnt <= 1) begin
                fib_done = 1'b1;
                fib_f    = fib_hold;
                fib_pend = 1'b0;
            end else begin
                fib_cnt--;
            end
        end
    end

    always @(negedge clk) begin
        bcd_done = 1'b0;
        if (!rst_n) begin
            bcd_pend = 1'b0;
        end else if (bcd_start) begin
            bcd_pend = 1'b1;
            bcd_cnt  = bcd_lat;
            bcd_hold = to_bcd(int'(bcd_bin));
        end else if (bcd_pend) begin
            if (bcd_cnt <= 1) begin
                bcd_done   = 1'b1;
                bcd_digits = bcd_hold;
                bcd_pend   = 1'b0;
            end else begin
                bcd_cnt--;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scoreboard monitor
    // -----------------------------------------------------------------------
    exp_t sb[$];
    int   n_b2b, n_fib, n_bcd;
    int   n_done   = 0;
    int   exp_ops  = 0;
    int   fib_cyc  = 0;
    int   done_cyc = 0;

    always @(negedge clk) begin
        exp_t it;
        if (rst_n) begin
            if (b2b_start) n_b2b++;
            if (fib_start) begin
                n_fib++;
                fib_cyc = cyc;
            end
            if (bcd_start) n_bcd++;
            if (done_tick) begin
                n_done++;
                done_cyc = cyc;
                if (sb.size() != 0) begin
                    it = sb.pop_front();
                    check("result", 64'(result), 64'(it.res));
                    check("ovf", 64'(ovf), 64'(it.ovf));
                    check("err", 64'(err), 64'(it.err));
                    check("b2b_start_cnt", 64'(n_b2b), 64'(it.nb));
                    check("fib_start_cnt", 64'(n_fib), 64'(it.nf));
                    check("bcd_start_cnt", 64'(n_bcd), 64'(it.nd));
                end
                n_b2b = 0;
                n_fib = 0;
                n_bcd = 0;
            end
        end
    end

    logic [49:0] outs;
    assign outs = {b2b_start, b2b_bcd, fib_start, fib_n, bcd_start, bcd_bin,
                   result, busy, done_tick, ovf, err};

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic wait_idle();
        for (int i = 0; i < 600 && busy; i++) @(negedge clk);
        check("idle_wait", 64'(busy), 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain", 64'(sb.size()), 64'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic drive_start(input logic [7:0] b);
        bcd_in = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] b, input int bl, input int fl, input int dl,
                          input exp_t e, input bit chk_lat);
        int t0;
        wait_idle();
        b2b_lat = bl;
        fib_lat = fl;
        bcd_lat = dl;
        sb.push_back(e);
        exp_ops++;
        t0 = cyc;
        drive_start(b);
        drain();
        if (chk_lat) check("latency_le10", 64'((done_cyc - t0 - 1) <= 10), 64'd1);
        @(negedge clk);
        check("done_tick_1cyc", 64'(done_tick), 64'd0);
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        logic [7:0] ops [6];
        bit         seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 8'h00;
        b2b_done = 1'b0; fib_done = 1'b0; bcd_done = 1'b0;
        b2b_bin = '0; fib_f = '0; bcd_digits = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", 64'(outs), 64'd0);

        // Nominal run, ideal sub-units
        run_op(8'h15, 1, 1, 1, exp_of(8'h15), 1'b1);
        check("t1_result_const", 64'(result), 64'h0610);

        // N_MAX boundary and zero
        run_op(8'h20, 3, 2, 4, exp_of(8'h20), 1'b0);
        check("t2_result_const", 64'(result), 64'h6765);
        run_op(8'h00, 2, 1, 3, exp_of(8'h00), 1'b0);

        // Out of range
        run_op(8'h21, 1, 1, 1, exp_of(8'h21), 1'b0);
        check("t3_ovf_held", 64'(ovf), 64'd1);
        run_op(8'h25, 2, 2, 2, exp_of(8'h25), 1'b0);

        // Invalid BCD digits
        run_op(8'h0a, 1, 1, 1, exp_of(8'h0a), 1'b0);
        check("t4_err_held", 64'(err), 64'd1);
        run_op(8'ha0, 1, 1, 1, exp_of(8'ha0), 1'b0);

        // Mixed operands and latencies
        ops = '{8'h10, 8'h99, 8'h07, 8'h9f, 8'h01, 8'h19};
        foreach (ops[i])
            run_op(ops[i], $urandom_range(6, 1), $urandom_range(6, 1),
                   $urandom_range(6, 1), exp_of(ops[i]), 1'b0);

        // Done arriving on the very edge the watchdog expires: done wins
        run_op(8'h15, 1, TIMEOUT_CYC - 1, 1, exp_of(8'h15), 1'b0);
        // bcd2bin one cycle too slow: watchdog abort in B2B
        run_op(8'h15, TIMEOUT_CYC, 1, 1, mk_exp(16'h0000, 1'b0, 1'b1, 1, 0, 0), 1'b0);
        @(negedge clk);

        // start landing in the DONE cycle is dropped
        wait_idle();
        b2b_lat = 1; fib_lat = 1; bcd_lat = 1;
        sb.push_back(exp_of(8'h12));
        exp_ops++;
        drive_start(8'h12);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = done_tick;
        end
        check("saw_done_tick", 64'(seen), 64'd1);
        drive_start(8'h05);
        check("start_in_done_ignored", 64'(busy), 64'd0);
        drain();

        // Hung fibonacci core, plus a start while busy
        wait_idle();
        fib_hang = 1'b1;
        sb.push_back(mk_exp(16'h0000, 1'b0, 1'b1, 1, 1, 0));
        exp_ops++;
        drive_start(8'h05);
        repeat (20) @(negedge clk);
        check("busy_in_fib", 64'(busy), 64'd1);
        drive_start(8'h07);
        drain();
        check("wd_cycles", 64'(done_cyc - fib_cyc), 64'(TIMEOUT_CYC));
        fib_hang = 1'b0;
        repeat (30) @(negedge clk);
        check("busy_start_not_queued", 64'(busy), 64'd0);
        check("done_count_a", 64'(n_done), 64'(exp_ops));

        // Reset in the middle of FIB
        fib_lat = 40;
        drive_start(8'h12);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = fib_start;
        end
        check("saw_fib_start", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 64'(outs), 64'd0);
        n_b2b = 0; n_fib = 0; n_bcd = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("idle_after_reset", 64'(outs), 64'd0);
        run_op(8'h10, 1, 1, 1, exp_of(8'h10), 1'b0);
        check("t6_result_const", 64'(result), 64'h0055);

        repeat (10) @(negedge clk);
        check("done_count_final", 64'(n_done), 64'(exp_ops));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
